eth_phy_10g_rx_ber_mon: RTL
===========================

# eth_phy_10g_rx_ber_mon

Receive-side 64b/66b bit-error-rate monitor (IEEE 802.3 Clause 49, Figure 49-13), downstream of the 10G RX frame aligner. Samples the aligned 2-bit sync header and block-lock status once per clock, counts invalid headers inside a fixed 125 µs window, and asserts high-BER when the count reaches threshold. Output feeds the RX status logic and the PCS decoder's error path.

## Interface
- `COUNT_125US`, 19531, window length in clk cycles (125 µs at 156.25 MHz block rate); sim benches override with a small value
- `BER_THRESH`, 16, invalid headers per window that trigger high-BER
- `HDR_WIDTH`, 2, sync header width
- `clk`  in  1  block clock, one 66-bit block per cycle
- `rst`  in  1  reset, synchronous, active-high
- `i_serdes_rx_hdr`  in  HDR_WIDTH  aligned sync header from frame aligner
- `i_rx_block_lock`  in  1  block lock from frame aligner
- `o_rx_high_ber`  out  1  high bit-error-rate flag, registered
- `o_ber_state`  out  2  current FSM state (debug)

## Operation
- Header valid iff `i_serdes_rx_hdr` is 2'b01 or 2'b10; 2'b00/2'b11 invalid.
- FSM states: INIT, TEST, HI_BER.
  - INIT: entered on `rst` or whenever `i_rx_block_lock`=0 (overrides any state). Timer=0, ber_cnt=0, high_ber=0. Leaves to TEST on the first cycle with lock=1; that cycle is window cycle 0 and its header is counted.
  - TEST: each cycle with invalid header, ber_cnt += 1. When ber_cnt reaches `BER_THRESH` -> HI_BER, high_ber=1. On window end with ber_cnt < `BER_THRESH`: high_ber=0, ber_cnt=0, new window, stay TEST.
  - HI_BER: high_ber held 1; invalid headers not counted. On window end: ber_cnt=0, new window, -> TEST with high_ber still 1 (clears only at the end of a subsequent window with < `BER_THRESH` errors).
- Timer: counts 0..`COUNT_125US`-1 while locked, wraps to 0; window end = cycle with timer = `COUNT_125US`-1. Never stops while locked (HI_BER included).
- ber_cnt: $clog2(`BER_THRESH`+1) bits, saturates at `BER_THRESH`.
- Simultaneous: invalid header on window-end cycle is counted first; if that makes ber_cnt = `BER_THRESH`, -> HI_BER (high_ber=1) and the new window starts with ber_cnt=0.
- Lock loss mid-window: next cycle INIT, high_ber=0, all counters cleared; window restarts on relock.

## Timing
- Reset values: `o_rx_high_ber`=0, `o_ber_state`=INIT, `o_ber_count`=0 (when present).
- `o_rx_high_ber` rises the cycle after the clock edge sampling the `BER_THRESH`-th invalid header.
- Falls the cycle after the window-end cycle of a clean window, or the cycle after lock loss.
- Window exactly `COUNT_125US` cycles; no gaps between windows.

## Configuration
- `ETH_BER_COUNT_OUT_EN` defined: adds ports `i_ber_count_clr` in 1 and `o_ber_count` out 6. 6-bit count of invalid headers seen while locked (all states), saturating at 63, independent of window resets. `i_ber_count_clr`=1 clears it; clear and increment in the same cycle yield 1.
- Undefined: both ports and the counter absent; all other behaviour identical.

## Structure
- Shared package `eth_phy_10g_pkg`: BER FSM state encodings, valid header codes 2'b01/2'b10, default `COUNT_125US` and `BER_THRESH`.
- One sub-module: `eth_phy_10g_rx_ber_timer` (free-running window counter with synchronous clear, `done` pulse on last cycle).

## Test plan
(All with `COUNT_125US`=100, `BER_THRESH`=16.)
- Reset, lock=1, all headers 2'b01 for 500 cycles -> `o_rx_high_ber` stays 0.
- 16 headers 2'b00 in cycles 10-25 of a window -> high_ber=1 at cycle 26; held through next window if it is clean, 0 the cycle after its window-end cycle.
- 15 invalid headers per window for 5 windows -> high_ber never asserts; ber_cnt cleared each window.
- 15 invalid in cycles 0-14, 16th on window-end cycle 99 -> high_ber=1 next cycle; following window starts at ber_cnt=0.
- HI_BER, then `i_rx_block_lock`=0 one cycle mid-window -> high_ber=0 next cycle, state INIT; relock restarts window at cycle 0.
- With `ETH_BER_COUNT_OUT_EN`: 70 invalid headers -> `o_ber_count`=63; clr with simultaneous invalid header -> 1.

Source files
------------

// File: rtl/eth_phy_10g_pkg.sv
// Shared 10G PCS definitions: BER FSM state codes, sync header codes, default BER window/threshold.
// Constants only; no logic, no latency, no flow control.
package eth_phy_10g_pkg;

    typedef enum logic [1:0] {
        BER_INIT   = 2'd0,
        BER_TEST   = 2'd1,
        BER_HI_BER = 2'd2
    } ber_state_t;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    localparam int COUNT_125US_DEF = 19531;
    localparam int BER_THRESH_DEF  = 16;

    function automatic logic sync_hdr_ok(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/eth_phy_10g_rx_ber_timer.sv
// BER window timer: counts 0..COUNT-1 and wraps; done is high on the last cycle (combinational from count).
// Synchronous clear takes effect on the next edge; no backpressure, runs every cycle.
module eth_phy_10g_rx_ber_timer #(
    parameter int COUNT = 19531
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic done
);
    localparam int W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [W-1:0] LAST = W'(COUNT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign done = (cnt == LAST);

endmodule

// File: rtl/eth_phy_10g_rx_ber_mon.sv
// 64b/66b RX BER monitor: counts invalid sync headers per 125 us window, flags high BER one cycle after threshold.
// No backpressure; samples one header per cycle. Optional lifetime count port under ETH_BER_COUNT_OUT_EN.
module eth_phy_10g_rx_ber_mon
    import eth_phy_10g_pkg::*;
#(
    parameter int COUNT_125US = COUNT_125US_DEF,
    parameter int BER_THRESH  = BER_THRESH_DEF,
    parameter int HDR_WIDTH   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [HDR_WIDTH-1:0] i_serdes_rx_hdr,
    input  logic                 i_rx_block_lock,
`ifdef ETH_BER_COUNT_OUT_EN
    input  logic                 i_ber_count_clr,
    output logic [5:0]           o_ber_count,
`endif
    output logic                 o_rx_high_ber,
    output logic [1:0]           o_ber_state
);
    localparam int CW = $clog2(BER_THRESH + 1);
    localparam logic [CW-1:0] THRESH_C = CW'(BER_THRESH);

    ber_state_t    state;
    logic [CW-1:0] ber_cnt;
    logic [CW-1:0] cnt_inc;
    logic          high_ber;
    logic          hdr_bad;
    logic          win_done;

    assign hdr_bad = !sync_hdr_ok(2'(i_serdes_rx_hdr));

    eth_phy_10g_rx_ber_timer #(
        .COUNT (COUNT_125US)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (!i_rx_block_lock),
        .done (win_done)
    );

    always_comb begin
        cnt_inc = ber_cnt;
        if (hdr_bad && (ber_cnt != THRESH_C)) begin
            cnt_inc = ber_cnt + CW'(1);
        end
    end

    // INIT with lock present behaves as window cycle 0 of TEST, so both share one branch.
    always_ff @(posedge clk) begin
        if (rst || !i_rx_block_lock) begin
            state    <= BER_INIT;
            ber_cnt  <= '0;
            high_ber <= 1'b0;
        end else begin
            case (state)
                BER_INIT, BER_TEST: begin
                    if (cnt_inc == THRESH_C) begin
                        state    <= BER_HI_BER;
                        high_ber <= 1'b1;
                        ber_cnt  <= win_done ? '0 : cnt_inc;
                    end else if (win_done) begin
                        state    <= BER_TEST;
                        high_ber <= 1'b0;
                        ber_cnt  <= '0;
                    end else begin
                        state    <= BER_TEST;
                        ber_cnt  <= cnt_inc;
                    end
                end
                BER_HI_BER: begin
                    if (win_done) begin
                        state   <= BER_TEST;
                        ber_cnt <= '0;
                    end
                end
                default: begin
                    state    <= BER_INIT;
                    ber_cnt  <= '0;
                    high_ber <= 1'b0;
                end
            endcase
        end
    end

    assign o_rx_high_ber = high_ber;
    assign o_ber_state   = state;

`ifdef ETH_BER_COUNT_OUT_EN
    logic [5:0] ber_count_q;
    logic       count_hit;

    assign count_hit = i_rx_block_lock && hdr_bad;

    // Clear wins over the stored value but not over this cycle's error, hence clear+error gives 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            ber_count_q <= '0;
        end else if (i_ber_count_clr) begin
            ber_count_q <= {5'd0, count_hit};
        end else if (count_hit && (ber_count_q != 6'd63)) begin
            ber_count_q <= ber_count_q + 6'd1;
        end
    end

    assign o_ber_count = ber_count_q;
`endif

endmodule
